// File: rtl/mux_arbiter.sv
// Round-robin arbiter steering a 4:1 mux: one owner at a time,
// bounded tenure, selects track the grant.
// Ports: clk, rst (sync, high), req[3:0] in;
//        gnt[3:0] one-hot grant, S1/S0 mux select, busy out.
module mux_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic       S1,
  output logic       S0,
  output logic       busy
);

  localparam int CW = $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] HMAX = CW'(MAX_HOLD);
  localparam logic [CW-1:0] ONE = CW'(1);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t state, state_n;
  logic [1:0] owner, owner_n;
  logic [1:0] last, last_n;
  logic [CW-1:0] hold_cnt, hold_n;

  logic [3:0] cand;
  logic [1:0] win;
  logic [1:0] idx;
  logic       found;

  // While granted the owner is masked out so a forced
  // rotation can never re-pick it; on release its bit is
  // already low, so the same mask is harmless.
  always_comb begin
    cand  = req;
    win   = last;
    idx   = last;
    found = 1'b0;
    if (state == GRANT)
      cand = req & ~(4'b0001 << owner);
    for (int i = 0; i < 4; i++) begin
      idx = last + 2'(i + 1);
      if (!found && cand[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_n = state;
    owner_n = owner;
    last_n  = last;
    hold_n  = hold_cnt;
    unique case (state)
      IDLE: begin
        if (found) begin
          state_n = GRANT;
          owner_n = win;
          last_n  = win;
          hold_n  = ONE;
        end
      end
      GRANT: begin
        if (!req[owner] || hold_cnt == HMAX) begin
          if (found) begin
            owner_n = win;
            last_n  = win;
            hold_n  = ONE;
          end else if (!req[owner]) begin
            state_n = IDLE;
          end else begin
            // sole requester: restart tenure, keep grant
            hold_n = ONE;
          end
        end else begin
          hold_n = hold_cnt + ONE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      owner    <= 2'd0;
      last     <= 2'd3;
      hold_cnt <= '0;
    end else begin
      state    <= state_n;
      owner    <= owner_n;
      last     <= last_n;
      hold_cnt <= hold_n;
    end
  end

  // owner is kept through IDLE, so the selects hold
  // their last value while nobody is granted.
  assign gnt  = (state == GRANT) ? (4'b0001 << owner) : 4'b0000;
  assign S1   = owner[1];
  assign S0   = owner[0];
  assign busy = (state == GRANT);

endmodule

// File: tb/tb_mux_arbiter.sv
// Directed bench for mux_arbiter (MAX_HOLD=4) with an
// expected-output queue checked one cycle after each drive.
module tb_mux_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] gnt;
  logic       S1;
  logic       S0;
  logic       busy;

  int checks = 0;
  int errors = 0;

  logic [6:0] sb_q[$];

  mux_arbiter #(.MAX_HOLD(4)) dut (
    .clk (clk),
    .rst (rst),
    .req (req),
    .gnt (gnt),
    .S1  (S1),
    .S0  (S0),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] ex(
    input logic [3:0] g,
    input logic [1:0] s,
    input logic       b
  );
    return {g, s, b};
  endfunction

  task automatic step(
    input string      tag,
    input logic       r,
    input logic [3:0] rq,
    input logic [6:0] e
  );
    logic [6:0] obs;
    logic [6:0] exp_v;
    rst = r;
    req = rq;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    obs = {gnt, S1, S0, busy};
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $error("FAIL %s scoreboard empty", tag);
    end else begin
      exp_v = sb_q.pop_front();
      assert (obs === exp_v) else begin
        errors++;
        $error("FAIL %s got gnt/sel/busy %b exp %b",
               tag, obs, exp_v);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    req = 4'b0000;
    #2;

    // reset with all requests pending
    step("rst0", 1'b1, 4'b1111, ex(4'b0000, 2'd0, 1'b0));
    step("rst1", 1'b1, 4'b1111, ex(4'b0000, 2'd0, 1'b0));

    // full rotation, 4 cycles each, first grant right after reset
    for (int g = 0; g < 4; g++)
      for (int k = 0; k < 4; k++)
        step("rot", 1'b0, 4'b1111,
             ex(4'b0001 << g, 2'(g), 1'b1));
    step("rot_wrap", 1'b0, 4'b1111, ex(4'b0001, 2'd0, 1'b1));

    // handover without bubble: 0 -> 2
    step("ho_keep", 1'b0, 4'b0101, ex(4'b0001, 2'd0, 1'b1));
    step("ho_swap", 1'b0, 4'b0100, ex(4'b0100, 2'd2, 1'b1));

    // sole requester held well beyond tenure
    for (int k = 0; k < 20; k++)
      step("sole", 1'b0, 4'b0010, ex(4'b0010, 2'd1, 1'b1));

    // move to owner 3, drop to idle, then wrap to 0
    step("to3", 1'b0, 4'b1000, ex(4'b1000, 2'd3, 1'b1));
    step("idle0", 1'b0, 4'b0000, ex(4'b0000, 2'd3, 1'b0));
    step("idle1", 1'b0, 4'b0000, ex(4'b0000, 2'd3, 1'b0));
    step("wrap", 1'b0, 4'b1001, ex(4'b0001, 2'd0, 1'b1));

    // reset while owner 2 holds the grant
    step("to2", 1'b0, 4'b0100, ex(4'b0100, 2'd2, 1'b1));
    step("mid_rst", 1'b1, 4'b1111, ex(4'b0000, 2'd0, 1'b0));
    step("post_rst", 1'b0, 4'b1111, ex(4'b0001, 2'd0, 1'b1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_arbiter.md
# mux_arbiter

Round-robin arbiter that shares the 4:1 multiplexer datapath among four requesters. It samples a 4-bit request vector, grants one requester at a time, and drives the mux select lines `S1`/`S0` so the granted input reaches `Y`. A grant is held while its owner keeps requesting, up to a bounded tenure, and then passes to the next requester in rotation.

## Interface
- `MAX_HOLD`, default 8: maximum consecutive grant cycles for one owner when others are waiting. Legal range is ≥ 1.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req` in 4: request vector; bit i is requester i (0→A, 1→B, 2→C, 3→D).
- `gnt` out 4: one-hot grant, or all zero when idle.
- `S1` out 1: mux select MSB (owner index bit 1).
- `S0` out 1: mux select LSB (owner index bit 0).
- `busy` out 1: high whenever `gnt` is non-zero.

## Operation
- **State machine:** two states.
  - IDLE: no grant.
  - GRANT: `owner` register holds the current index.
- **Internal registers:**
  - `owner`: 2 bits.
  - `last`: 2 bits, index of the most recent owner.
  - `hold_cnt`: `$clog2(MAX_HOLD+1)` bits.
- **Reset** (`rst`=1 at an edge overrides everything):
  - State IDLE; `gnt`=0000, `S1S0`=00, `busy`=0.
  - `last`=3, so requester 0 has first priority.
  - `hold_cnt`=0.
- **Priority scan:** starts at `(last+1) mod 4` and wraps through 4 positions. The first asserted `req` bit wins.
- **IDLE:**
  - If `req`≠0: go to GRANT with the scan winner. Set `owner`=`last`=winner and `hold_cnt`=1.
  - Otherwise stay in IDLE. `S1S0` keeps its previous value.
- **GRANT:** at each edge, evaluate in this order.
  1. `req[owner]`=0 (release):
     - If any other `req` bit is set, hand over directly to the scan winner with no idle bubble, and set `hold_cnt`=1.
     - Otherwise go to IDLE.
  2. `req[owner]`=1, `hold_cnt`=`MAX_HOLD`, and some other `req` bit is set (forced rotation): grant the scan winner (never the current owner) and set `hold_cnt`=1.
  3. `req[owner]`=1, `hold_cnt`=`MAX_HOLD`, and no other request: keep the owner and set `hold_cnt`=1. A sole requester is never starved or dropped.
  4. Otherwise keep the owner and increment `hold_cnt`. The counter saturates at `MAX_HOLD`.
- **Select encoding:** in GRANT, `{S1,S0}` = `owner`, and `gnt` = `1<<owner`.
- **Width rules:**
  - Index arithmetic is mod 4, so 3+1 wraps to 0.
  - `hold_cnt` never exceeds `MAX_HOLD`.
- **Non-owner requests:** changes on non-owner `req` bits have no effect until the next arbitration point.
- **Invariant:** `gnt` is one-hot or zero at all times.

## Timing
- All outputs are registered and change only after a rising edge of `clk`.
- **Grant latency:** `req` sampled at edge k produces `gnt`, `S1S0` and `busy` valid after edge k. A new request is granted 1 cycle after it is first sampled.
- **Release latency:** owner deasserts `req` before edge k → `gnt` changes after edge k.
  - Handover to another requester completes in the same edge.
  - `busy` stays 1 across a handover.
- **Tenure:** with others waiting, an owner holds the grant for exactly `MAX_HOLD` consecutive cycles.
- **Reset timing:** `rst` asserted before edge k → all outputs are at reset values after edge k, including mid-grant.
- **Selects follow the grant:** `S1`/`S0` change in the same cycle as `gnt`, so the mux output follows the new owner with combinational delay only.

## Test plan
1. **Reset with pending requests:** hold `rst`=1 for 2 cycles with `req`=1111 → `gnt`=0000, `S1S0`=00, `busy`=0. On the first edge after release, `gnt`=0001, `S1S0`=00, `busy`=1.
2. **Full rotation:** `MAX_HOLD`=4, `req`=1111 held → the grants 0001, 0010, 0100, 1000 each last exactly 4 cycles, with `S1S0`=00, 01, 10, 11 respectively, then wrap back to 0001.
3. **Handover without bubble:** owner 0 granted and `req` goes from 0101 to 0100 → after the next edge `gnt`=0100, `S1S0`=10, and `busy` never drops.
4. **Sole requester beyond tenure:** `MAX_HOLD`=4, `req`=0010 for 20 cycles → `gnt`=0010 and `S1S0`=01 continuously.
5. **Return to idle and wrap:** owner 3 drops and `req`=0000 → `gnt`=0000, `busy`=0, `S1S0` holds 11. Then `req`=1001 → `gnt`=0001, because the scan starts at 0 after `last`=3.
6. **Reset mid-grant:** pulse `rst` while `gnt`=0100 with `req`=1111 → next cycle `gnt`=0000. After release, `gnt`=0001, confirming that `last` was reset.
